// File: rtl/audio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_arb_pkg
// Description : Shared types and constants for the audio register-write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int c_GAP_CYCLES_DEFAULT = 3;
    localparam int c_GAP_CNT_W          = 4;

endpackage
`default_nettype wire

// File: rtl/m_counter.sv
`default_nettype none
// ============================================================================
// Module      : m_counter
// Description : Loadable down-counter that saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module m_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/m_register.sv
`default_nettype none
// ============================================================================
// Module      : m_register
// Description : Enabled register with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module m_register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/m_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : m_rr_picker
// Description : Combinational round-robin picker; first set request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module m_rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [PW-1:0]   o_winner,
    output logic            o_any_req
);

    int w_idx;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_winner  = '0;
        o_any_req = 1'b0;
        w_idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (i_req[w_idx[PW-1:0]]) begin
                o_winner  = w_idx[PW-1:0];
                o_any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_audio_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : m_audio_write_arbiter
// Description : Round-robin arbiter for the audio register-write port with post-write gap.
// Revision    : 1.0 - initial release
// ============================================================================
module m_audio_write_arbiter
    import audio_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int AW         = 4,
    parameter int DW         = 8,
    parameter int GAP_CYCLES = c_GAP_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              busy
);

    localparam int c_PW = $clog2(NREQ);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [c_PW-1:0]         r_ptr;
    logic [c_PW-1:0]         r_winner;
    logic [c_PW-1:0]         w_pick;
    logic                    w_any_req;
    logic                    w_latch;
    logic [c_GAP_CNT_W-1:0]  w_gap_cnt;
    logic [AW-1:0]           w_sel_addr;
    logic [DW-1:0]           w_sel_data;

    m_rr_picker #(.NREQ(NREQ), .PW(c_PW)) u_picker (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_winner  (w_pick),
        .o_any_req (w_any_req)
    );

    assign w_latch    = (r_state == ST_IDLE) && w_any_req;
    assign w_sel_addr = req_addr[int'(w_pick)*AW +: AW];
    assign w_sel_data = req_data[int'(w_pick)*DW +: DW];

    m_register #(.W(AW)) u_addr_reg (
        .clk (clk), .clr_n (clr_n), .i_en (w_latch), .i_d (w_sel_addr), .o_q (wr_addr)
    );
    m_register #(.W(DW)) u_data_reg (
        .clk (clk), .clr_n (clr_n), .i_en (w_latch), .i_d (w_sel_data), .o_q (wr_data)
    );
    m_register #(.W(c_PW)) u_winner_reg (
        .clk (clk), .clr_n (clr_n), .i_en (w_latch), .i_d (w_pick), .o_q (r_winner)
    );

    // Loaded during the write cycle so GAP sees GAP_CYCLES on its first cycle.
    m_counter #(.W(c_GAP_CNT_W)) u_gap_cnt (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_load     (r_state == ST_WRITE),
        .i_load_val (c_GAP_CNT_W'(GAP_CYCLES)),
        .i_dec      (r_state == ST_GAP),
        .o_count    (w_gap_cnt)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_WRITE) begin
                r_ptr <= (r_winner == c_PW'(NREQ - 1)) ? '0 : r_winner + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (w_gap_cnt <= c_GAP_CNT_W'(1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en = (r_state == ST_WRITE);
        busy  = (r_state != ST_IDLE);
        ack   = '0;
        if (r_state == ST_WRITE) begin
            ack = NREQ'(1) << r_winner;
        end
    end

endmodule
`default_nettype wire
